// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state encoding, default frame geometry and counter width helper
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } seg_state_t;

    localparam int SEG_DATA_W = 64;
    localparam int SEG_DIV    = 4;

    // Counter width for a modulus of n; a modulus of 1 still needs one bit.
    function automatic int seg_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out shift register, MSB out, zero fill
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] p_in,
    output logic         s_out
);

    logic [W-1:0] r_shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= p_in;
        end else if (shift) begin
            r_shreg <= {r_shreg[W-2:0], 1'b0};
        end
    end

    assign s_out = r_shreg[W-1];

endmodule

// File: rtl/seg_p2s_ctrl.sv
// rtl/seg_p2s_ctrl.sv - serializes one display frame onto a 595-style chain, then latches
module seg_p2s_ctrl
    import seg_pkg::*;
#(
    parameter int DATA_W = SEG_DATA_W,
    parameter int DIV    = SEG_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              seg_clk,
    output logic              seg_dat,
    output logic              seg_latch,
    output logic              busy,
    output logic              done
);

    localparam int DIV_CW = seg_cnt_w(DIV);
    localparam int BIT_CW = seg_cnt_w(DATA_W);
    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);

    seg_state_t        r_state;
    seg_state_t        w_state_nxt;
    logic [DIV_CW-1:0] r_div_cnt;
    logic [DIV_CW-1:0] w_div_nxt;
    logic [BIT_CW-1:0] r_bit_cnt;
    logic [BIT_CW-1:0] w_bit_nxt;
    logic              w_div_end;
    logic              w_load;
    logic              w_shift;
    logic              w_s_out;
    logic              r_seg_clk;
    logic              r_seg_latch;
    logic              r_busy;
    logic              r_done;

    assign w_div_end = (r_div_cnt == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                w_div_nxt = '0;
                if (start) begin
                    w_state_nxt = SHIFT_LO;
                    w_bit_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (w_div_end) begin
                    w_state_nxt = SHIFT_HI;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + DIV_CW'(1);
                end
            end
            SHIFT_HI: begin
                if (w_div_end) begin
                    w_state_nxt = (r_bit_cnt == BIT_LAST) ? LATCH : SHIFT_LO;
                    w_div_nxt   = '0;
                    w_bit_nxt   = r_bit_cnt + BIT_CW'(1);
                    w_shift     = 1'b1;
                end else begin
                    w_div_nxt = r_div_cnt + DIV_CW'(1);
                end
            end
            LATCH: begin
                if (w_div_end) begin
                    w_state_nxt = IDLE;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + DIV_CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_div_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_seg_clk   <= 1'b0;
            r_seg_latch <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_seg_clk   <= (w_state_nxt == SHIFT_HI);
            r_seg_latch <= (w_state_nxt == LATCH);
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (r_state == LATCH) && (w_state_nxt == IDLE);
        end
    end

    // After DATA_W zero-filled shifts the register is empty, so its MSB is already 0 in LATCH/IDLE.
    piso_shift_reg #(
        .W(DATA_W)
    ) u_piso (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .shift(w_shift),
        .p_in (data),
        .s_out(w_s_out)
    );

    assign seg_clk   = r_seg_clk;
    assign seg_dat   = w_s_out;
    assign seg_latch = r_seg_latch;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_seg_p2s_ctrl.sv
// tb/tb_seg_p2s_ctrl.sv - scoreboard bench for seg_p2s_ctrl in a 16/2 and a 64/4 configuration
module tb_seg_p2s_ctrl;

    localparam int LAT_A = 2 * 2 * 16 + 2;
    localparam int LAT_B = 2 * 4 * 64 + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [63:0] data;
    logic        sel;

    logic a_seg_clk, a_seg_dat, a_seg_latch, a_busy, a_done;
    logic b_seg_clk, b_seg_dat, b_seg_latch, b_busy, b_done;
    logic m_clk, m_dat, m_latch, m_busy, m_done;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int latch_cnt = 0;
    int busy_gap  = 0;
    logic prev_clk = 1'b0;
    bit exp_bits[$];
    int exp_done[$];

    seg_p2s_ctrl #(.DATA_W(16), .DIV(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data(data[15:0]),
        .seg_clk(a_seg_clk), .seg_dat(a_seg_dat), .seg_latch(a_seg_latch),
        .busy(a_busy), .done(a_done)
    );

    seg_p2s_ctrl #(.DATA_W(64), .DIV(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data),
        .seg_clk(b_seg_clk), .seg_dat(b_seg_dat), .seg_latch(b_seg_latch),
        .busy(b_busy), .done(b_done)
    );

    assign m_clk   = sel ? b_seg_clk   : a_seg_clk;
    assign m_dat   = sel ? b_seg_dat   : a_seg_dat;
    assign m_latch = sel ? b_seg_latch : a_seg_latch;
    assign m_busy  = sel ? b_busy      : a_busy;
    assign m_done  = sel ? b_done      : a_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected bits on every seg_clk rise and expected done cycles on every done.
    always @(negedge clk) begin
        int lat_c;
        int div_c;
        int off;
        lat_c = sel ? LAT_B : LAT_A;
        div_c = sel ? 4 : 2;
        if (m_clk && !prev_clk) begin
            chk("rise_expected", 64'(exp_bits.size() != 0), 64'd1);
            if (exp_bits.size() != 0) chk("seg_dat_at_rise", 64'(m_dat), 64'(exp_bits.pop_front()));
        end
        prev_clk = m_clk;
        if (exp_done.size() != 0) begin
            if (m_done) begin
                chk("done_cycle", 64'(cyc), 64'(exp_done[0]));
                chk("latch_cycles", 64'(latch_cnt), 64'(div_c));
                chk("busy_gap", 64'(busy_gap), 64'd0);
                chk("busy_at_done", 64'(m_busy), 64'd0);
                void'(exp_done.pop_front());
                latch_cnt = 0;
                busy_gap  = 0;
            end else begin
                off = cyc - (exp_done[0] - lat_c);
                if (off >= 1 && off <= lat_c - 1 && !m_busy) busy_gap++;
                if (m_latch) latch_cnt++;
            end
        end else begin
            chk("idle_quiet", {61'd0, m_clk, m_latch, m_done}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, output int acc);
        int w;
        w = sel ? 64 : 16;
        data = d;
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        for (int i = w - 1; i >= 0; i--) exp_bits.push_back(d[i]);
        acc = cyc + 1;
        exp_done.push_back(acc + (sel ? LAT_B : LAT_A));
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic flush();
        exp_bits.delete();
        exp_done.delete();
        latch_cnt = 0;
        busy_gap  = 0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && exp_done.size() != 0; i++) tick();
        if (exp_done.size() != 0) begin
            chk("frame_timeout", 64'(exp_done.size()), 64'd0);
            flush();
        end
        chk("bits_consumed", 64'(exp_bits.size()), 64'd0);
    endtask

    initial begin
        int acc;
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1; data = '1; sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs_a", {59'd0, a_seg_clk, a_seg_dat, a_seg_latch, a_busy, a_done}, 64'd0);
            chk("reset_outputs_b", {59'd0, b_seg_clk, b_seg_dat, b_seg_latch, b_busy, b_done}, 64'd0);
        end
        tick();
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; data = '0;
        tick();
        chk("no_accept_from_reset", 64'(a_busy), 64'd0);

        // Single frame with a second start landing mid-frame.
        send(64'hA5C3, acc);
        repeat (9) tick();
        start_a = 1'b1; data = 64'hFFFF;
        tick();
        start_a = 1'b0;
        wait_done(150);
        repeat (4) tick();

        // Back-to-back: start held high, second frame accepted in the done cycle.
        data = 64'h0001; start_a = 1'b1;
        for (int i = 15; i >= 0; i--) exp_bits.push_back(data[i]);
        exp_done.push_back(cyc + 1 + LAT_A);
        tick();
        acc = cyc;
        data = 64'h8000;
        for (int i = 15; i >= 0; i--) exp_bits.push_back(data[i]);
        exp_done.push_back(acc + LAT_A + 1 + LAT_A);
        repeat (LAT_A + 1) tick();
        start_a = 1'b0;
        wait_done(200);
        repeat (4) tick();

        // Mid-frame reset, then a clean frame.
        send(64'h5A0F, acc);
        repeat (29) tick();
        rst = 1'b1;
        tick();
        flush();
        @(negedge clk);
        chk("abort_outputs", {59'd0, a_seg_clk, a_seg_dat, a_seg_latch, a_busy, a_done}, 64'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        send(64'h3C96, acc);
        wait_done(150);
        repeat (4) tick();

        // Default geometry.
        sel = 1'b1;
        tick();
        send(64'h0123_4567_89AB_CDEF, acc);
        wait_done(700);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
